scan_decoder: RTL
=================

// Module: scan_decoder
// PURPOSE
//  Parametrised AW-to-2^AW one-hot decoder with registered output and a built-in index sequencer.
//  Modes: direct load of an index, or automatic up/down scan with programmable dwell and optional one-shot.
//  Generalises the fixed 6-to-64 combinational decoder.
//  Drives row/column select, LED-matrix scan and walking-one test patterns.
// PARAMETERS
//  AW      6    index width; output width OW = 2**AW (localparam, not overridable)
//  DIV     4    dwell: clock cycles each index is held during scan (>=1)
//  ACT_LOW 0    1 -> y is active-low (one-cold); all-off value becomes all-ones
// PORTS
//  clk      in   1     clock, rising edge
//  reset    in   1     synchronous, active-high
//  en       in   1     output enable; 0 forces y to all-off, sequencer frozen
//  mode     in   2     00 OFF, 01 LOAD, 10 SCAN_UP, 11 SCAN_DOWN (sampled every cycle)
//  a        in   AW    index for LOAD and scan start point
//  start    in   1     1-cycle strobe: acts on the current mode
//  oneshot  in   1     sampled with start; 1 -> scan stops after one full pass
//  y        out  OW    registered one-hot (or one-cold) select
//  idx      out  AW    current index register
//  wrap     out  1     1-cycle pulse when scan passes the terminal index
//  busy     out  1     1 while in SCAN state
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high.
//  Reset values (priority over all inputs): state=IDLE, idx=0, dwell=0, wrap=0, busy=0, y=all-off.
//  FSM states: IDLE, HOLD, SCAN.
//   IDLE -> HOLD on start & mode==LOAD: idx<=a.
//   IDLE -> SCAN on start & mode==SCAN_*: idx<=a, dwell<=0, os_latch<=oneshot.
//   HOLD/SCAN -> IDLE when mode==OFF (no strobe needed).
//   HOLD/SCAN: a new start behaves as from IDLE, i.e. restart/retarget.
//   SCAN -> HOLD on one-shot completion.
//  Output: y <= en ? onehot(idx_next) : all-off. Latency is 1 cycle from start to y.
//   y is all-off in IDLE.
//  Scan step: dwell counts 0..DIV-1; at dwell==DIV-1, dwell<=0 and idx steps +1 (UP) or -1 (DOWN).
//   idx wraps modulo 2**AW.
//  Terminal index: 2**AW-1 for UP, 0 for DOWN.
//   Stepping off the terminal index pulses wrap for exactly the cycle idx takes its new value.
//  One-shot: on wrap, the FSM goes to HOLD with idx at the wrapped value (0 for UP, 2**AW-1 for DOWN). busy drops with it.
//  Direction change mid-scan (mode UP<->DOWN without start): takes effect at the next step. dwell is not reset.
//  Simultaneous start and a scheduled step: start wins. No step and no wrap that cycle.
//  en=0: state, idx and dwell hold; wrap is suppressed; y goes all-off next cycle.
//   On en rising, resume exactly where frozen.
//  DIV==1: idx steps every cycle.
//  Reset asserted mid-scan: next edge gives the reset values; busy is 0 on the following cycle.
// STRUCTURE
//  scan_decoder_pkg:
//   typedef enum logic [1:0] mode_e {M_OFF, M_LOAD, M_SCAN_UP, M_SCAN_DN}
//   typedef enum logic [1:0] state_e {S_IDLE, S_HOLD, S_SCAN}
//  Sub-module onehot_dec #(AW, ACT_LOW): purely combinational index->select.
//   Instantiated once on idx_next; its output is registered in scan_decoder.
//  Dwell counter width: $clog2(DIV) bits, minimum 1.
// TESTING (AW=6, DIV=4, ACT_LOW=0 unless noted)
//  1. Load sweep: for a=0..63, start with LOAD -> y==64'h1<<a one cycle later; idx==a; busy==0.
//  2. Scan up, continuous: a=62, start -> y bit62 for 4 cycles, bit63 for 4, then bit0.
//     wrap=1 on the cycle y==64'h1; the pattern repeats.
//  3. One-shot down: a=1, oneshot=1, SCAN_DOWN -> 1, 0, 63 after 8 cycles.
//     wrap pulses once; state HOLD; busy=0; y==64'h1<<63 held.
//  4. en=0 for 10 cycles mid-scan at idx=5, dwell=2 -> y==0, idx stays 5.
//     After en=1, idx 5 is held 2 more cycles, then 6.
//  5. Start and step coincide at dwell==3 with a=40 -> idx==40 next cycle, no wrap.
//     Reset mid-scan -> y==0, idx==0, busy==0 on the following cycle.
//  6. ACT_LOW=1, DIV=1: LOAD a=3 -> y==~(64'h8).
//     SCAN_UP from 63 -> y==~64'h1 with wrap the next cycle.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan decoder: mode and FSM state encodings,
// plus the dwell counter width rule.
package scan_decoder_pkg;

    typedef enum logic [1:0] {
        M_OFF     = 2'b00,
        M_LOAD    = 2'b01,
        M_SCAN_UP = 2'b10,
        M_SCAN_DN = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HOLD = 2'b01,
        S_SCAN = 2'b10
    } state_e;

    // A dwell of one cycle still needs a one-bit counter.
    function automatic int dwell_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational index-to-select decoder; optional active-low (one-cold) output.
module onehot_dec #(
    parameter int AW      = 6,
    parameter bit ACT_LOW = 1'b0
) (
    input  logic [AW-1:0]      idx,
    output logic [2**AW-1:0]   sel
);

    localparam int OW = 2**AW;

    logic [OW-1:0] hot;

    always_comb begin
        hot      = '0;
        hot[idx] = 1'b1;
    end

    assign sel = ACT_LOW ? ~hot : hot;

endmodule

// File: rtl/scan_decoder.sv
// One-hot select decoder with registered output and an index sequencer
// (direct load, or up/down scan with programmable dwell and optional one-shot).
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int AW      = 6,
    parameter int DIV     = 4,
    parameter bit ACT_LOW = 1'b0,
    localparam int OW     = 2**AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] a,
    input  logic          start,
    input  logic          oneshot,
    output logic [OW-1:0] y,
    output logic [AW-1:0] idx,
    output logic          wrap,
    output logic          busy
);

    localparam int            DW         = dwell_width(DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DIV - 1);
    localparam logic [AW-1:0] IDX_TOP    = '1;
    localparam logic [OW-1:0] ALL_OFF    = {OW{ACT_LOW}};

    state_e        state, state_next;
    mode_e         cur_mode;
    logic [AW-1:0] idx_next;
    logic [DW-1:0] dwell, dwell_next;
    logic          os_latch, os_next;
    logic          wrap_next;
    logic [OW-1:0] sel;

    assign cur_mode = mode_e'(mode);

    onehot_dec #(
        .AW      (AW),
        .ACT_LOW (ACT_LOW)
    ) u_dec (
        .idx (idx_next),
        .sel (sel)
    );

    // With en low everything holds; a start strobe outranks a scheduled step.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        dwell_next = dwell;
        os_next    = os_latch;
        wrap_next  = 1'b0;
        if (en) begin
            if (start && (cur_mode == M_LOAD)) begin
                state_next = S_HOLD;
                idx_next   = a;
            end else if (start && ((cur_mode == M_SCAN_UP) || (cur_mode == M_SCAN_DN))) begin
                state_next = S_SCAN;
                idx_next   = a;
                dwell_next = '0;
                os_next    = oneshot;
            end else if (cur_mode == M_OFF) begin
                state_next = S_IDLE;
            end else if ((state == S_SCAN) && (cur_mode != M_LOAD)) begin
                if (dwell == DWELL_LAST) begin
                    dwell_next = '0;
                    if (cur_mode == M_SCAN_UP) begin
                        idx_next  = idx + 1'b1;
                        wrap_next = (idx == IDX_TOP);
                    end else begin
                        idx_next  = idx - 1'b1;
                        wrap_next = (idx == '0);
                    end
                    if (wrap_next && os_latch) begin
                        state_next = S_HOLD;
                    end
                end else begin
                    dwell_next = dwell + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            dwell    <= '0;
            os_latch <= 1'b0;
            wrap     <= 1'b0;
            y        <= ALL_OFF;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            dwell    <= dwell_next;
            os_latch <= os_next;
            wrap     <= wrap_next;
            y        <= (en && (state_next != S_IDLE)) ? sel : ALL_OFF;
        end
    end

    assign busy = (state == S_SCAN);

endmodule
